// File: rtl/multicycle_control.sv
// Multi-cycle RV32-subset sequencer: IF/ID/EX/MEM/WB over a shared single-port memory.
// Optional MC_ILLEGAL_TRAP_EN adds a sticky ERR state for unknown opcodes.
module multicycle_control (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] Op_i,
    input  logic       Zero_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       PCSrc_o,
    output logic       IRWrite_o,
    output logic       InstRead_o,
    output logic [1:0] ALUOp_o,
    output logic       ALUSrc_o,
    output logic       RegWrite_o,
    output logic       MemtoReg_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       done_o,
    output logic       illegal_o
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5
    } state_t;

    state_t     state, next_state;
    logic [6:0] op_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IF;
            op_q  <= 7'd0;
        end else begin
            state <= next_state;
            if (state == S_ID)
                op_q <= Op_i;
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            illegal_q <= 1'b0;
        else if (state == S_EX && next_state == S_ERR)
            illegal_q <= 1'b1;
    end

    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif

    always_comb begin
        next_state = S_IF;
        case (state)
            S_IF:  next_state = mem_ready_i ? S_ID : S_IF;
            S_ID:  next_state = S_EX;
            S_EX: begin
                case (op_q)
                    OP_R, OP_I:   next_state = S_WB;
                    OP_LW, OP_SW: next_state = S_MEM;
                    OP_BEQ:       next_state = S_IF;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      next_state = S_ERR;
`else
                    default:      next_state = S_IF;
`endif
                endcase
            end
            S_MEM: begin
                if (!mem_ready_i)
                    next_state = S_MEM;
                else
                    next_state = (op_q == OP_LW) ? S_WB : S_IF;
            end
            S_WB:  next_state = S_IF;
`ifdef MC_ILLEGAL_TRAP_EN
            S_ERR: next_state = S_ERR;
`endif
            default: next_state = S_IF;
        endcase
    end

    always_comb begin
        PCWrite_o  = 1'b0;
        PCSrc_o    = 1'b0;
        IRWrite_o  = 1'b0;
        InstRead_o = 1'b0;
        ALUOp_o    = 2'b00;
        ALUSrc_o   = 1'b0;
        RegWrite_o = 1'b0;
        MemtoReg_o = 1'b0;
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        done_o     = 1'b0;
        case (state)
            S_IF: begin
                InstRead_o = 1'b1;
                IRWrite_o  = mem_ready_i;
                PCWrite_o  = mem_ready_i;
            end
            S_EX: begin
                case (op_q)
                    OP_R: ALUOp_o = 2'b10;
                    OP_I, OP_LW, OP_SW: ALUSrc_o = 1'b1;
                    OP_BEQ: begin
                        ALUOp_o   = 2'b01;
                        PCSrc_o   = 1'b1;
                        PCWrite_o = Zero_i;
                        done_o    = 1'b1;
                    end
`ifdef MC_ILLEGAL_TRAP_EN
                    default: ;
`else
                    default: done_o = 1'b1;
`endif
                endcase
            end
            S_MEM: begin
                if (op_q == OP_LW) begin
                    MemRead_o = 1'b1;
                end else begin
                    MemWrite_o = 1'b1;
                    done_o     = mem_ready_i;
                end
            end
            S_WB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = (op_q == OP_LW);
                done_o     = 1'b1;
            end
            default: ;
        endcase
        // state sits at IF while reset is held, so the fetch request must be masked here
        if (rst_i) begin
            PCWrite_o  = 1'b0;
            PCSrc_o    = 1'b0;
            IRWrite_o  = 1'b0;
            InstRead_o = 1'b0;
            ALUOp_o    = 2'b00;
            ALUSrc_o   = 1'b0;
            RegWrite_o = 1'b0;
            MemtoReg_o = 1'b0;
            MemRead_o  = 1'b0;
            MemWrite_o = 1'b0;
            done_o     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; expectations are hand-computed
// output vectors per cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_src, ir_write, inst_read;
    logic [1:0] alu_op;
    logic       alu_src, reg_write, mem_to_reg, mem_read, mem_write, done, illegal;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_control dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .Op_i        (op),
        .Zero_i      (zero),
        .mem_ready_i (mem_ready),
        .PCWrite_o   (pc_write),
        .PCSrc_o     (pc_src),
        .IRWrite_o   (ir_write),
        .InstRead_o  (inst_read),
        .ALUOp_o     (alu_op),
        .ALUSrc_o    (alu_src),
        .RegWrite_o  (reg_write),
        .MemtoReg_o  (mem_to_reg),
        .MemRead_o   (mem_read),
        .MemWrite_o  (mem_write),
        .done_o      (done),
        .illegal_o   (illegal)
    );

    always #5 clk = ~clk;

    // vector: pcw pcs irw ird | aluop alusrc | rw m2r | mr mw | done ill
    localparam logic [12:0] V_ZERO    = 13'b0000_000_00_00_00;
    localparam logic [12:0] V_IF_WAIT = 13'b0001_000_00_00_00;
    localparam logic [12:0] V_IF_ACK  = 13'b1011_000_00_00_00;
    localparam logic [12:0] V_EX_R    = 13'b0000_100_00_00_00;
    localparam logic [12:0] V_EX_IMM  = 13'b0000_001_00_00_00;
    localparam logic [12:0] V_WB_ALU  = 13'b0000_000_10_00_10;
    localparam logic [12:0] V_WB_LW   = 13'b0000_000_11_00_10;
    localparam logic [12:0] V_BEQ_T   = 13'b1100_010_00_00_10;
    localparam logic [12:0] V_BEQ_N   = 13'b0100_010_00_00_10;
    localparam logic [12:0] V_MEM_RD  = 13'b0000_000_00_10_00;
    localparam logic [12:0] V_SW_ACK  = 13'b0000_000_00_01_10;
    localparam logic [12:0] V_NOP_EX  = 13'b0000_000_00_00_10;
    localparam logic [12:0] V_ERR     = 13'b0000_000_00_00_01;

    logic [12:0] obs;
    assign obs = {pc_write, pc_src, ir_write, inst_read, alu_op, alu_src,
                  reg_write, mem_to_reg, mem_read, mem_write, done, illegal};

    // Check the current cycle mid-period, then advance to just past the next rising edge.
    task automatic cyc(input string tag, input logic [12:0] exp);
        @(negedge clk);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        n_cmp++;
        assert ($onehot0({inst_read, mem_read, mem_write})) else begin
            n_bad++;
            $error("FAIL %s_req_excl: observed %b expected at most one high", tag,
                   {inst_read, mem_read, mem_write});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        op        = 7'b0110011;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", V_ZERO);
        rst = 1'b0;

        // add, zero-wait
        cyc("add_if", V_IF_ACK);
        cyc("add_id", V_ZERO);
        cyc("add_ex", V_EX_R);
        cyc("add_wb", V_WB_ALU);

        // addi
        op = 7'b0010011;
        cyc("addi_if", V_IF_ACK);
        cyc("addi_id", V_ZERO);
        cyc("addi_ex", V_EX_IMM);
        cyc("addi_wb", V_WB_ALU);

        // lw: 2 fetch waits, ready ignored in ID/EX, 3 MEM waits
        op = 7'b0000011;
        mem_ready = 1'b0;
        cyc("lw_if_w1", V_IF_WAIT);
        cyc("lw_if_w2", V_IF_WAIT);
        mem_ready = 1'b1;
        cyc("lw_if_ack", V_IF_ACK);
        mem_ready = 1'b0;
        cyc("lw_id", V_ZERO);
        cyc("lw_ex", V_EX_IMM);
        cyc("lw_mem_w1", V_MEM_RD);
        cyc("lw_mem_w2", V_MEM_RD);
        cyc("lw_mem_w3", V_MEM_RD);
        mem_ready = 1'b1;
        cyc("lw_mem_ack", V_MEM_RD);
        cyc("lw_wb", V_WB_LW);

        // beq taken / not taken
        op = 7'b1100011;
        zero = 1'b1;
        cyc("beq_t_if", V_IF_ACK);
        cyc("beq_t_id", V_ZERO);
        cyc("beq_t_ex", V_BEQ_T);
        zero = 1'b0;
        cyc("beq_n_if", V_IF_ACK);
        cyc("beq_n_id", V_ZERO);
        cyc("beq_n_ex", V_BEQ_N);

        // sw, zero-wait
        op = 7'b0100011;
        cyc("sw_if", V_IF_ACK);
        cyc("sw_id", V_ZERO);
        cyc("sw_ex", V_EX_IMM);
        cyc("sw_mem", V_SW_ACK);

        // reset during lw MEM wait
        op = 7'b0000011;
        cyc("rlw_if", V_IF_ACK);
        cyc("rlw_id", V_ZERO);
        cyc("rlw_ex", V_EX_IMM);
        mem_ready = 1'b0;
        cyc("rlw_mem_w", V_MEM_RD);
        rst = 1'b1;
        cyc("rlw_in_reset", V_ZERO);
        rst = 1'b0;
        mem_ready = 1'b1;
        op = 7'b0110011;
        cyc("rlw_restart_if", V_IF_ACK);
        cyc("rlw_restart_id", V_ZERO);
        cyc("rlw_restart_ex", V_EX_R);
        cyc("rlw_restart_wb", V_WB_ALU);

        // unknown opcode
        op = 7'b1111111;
        cyc("ill_if", V_IF_ACK);
        cyc("ill_id", V_ZERO);
`ifdef MC_ILLEGAL_TRAP_EN
        cyc("ill_ex", V_ZERO);
        cyc("ill_err1", V_ERR);
        cyc("ill_err2", V_ERR);
        cyc("ill_err3", V_ERR);
        rst = 1'b1;
        cyc("ill_reset", V_ZERO);
        rst = 1'b0;
        op = 7'b0110011;
        cyc("ill_after_if", V_IF_ACK);
`else
        cyc("ill_ex_nop", V_NOP_EX);
        op = 7'b0110011;
        cyc("ill_next_if", V_IF_ACK);
        cyc("ill_next_id", V_ZERO);
        cyc("ill_next_ex", V_EX_R);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32 subset datapath (R-type, I-type ALU, lw, sw, beq). It walks each instruction through fetch, decode, execute, memory and write-back states over a shared single-port memory, and holds every request until the memory acknowledges it. It replaces single-cycle opcode decoding in the multi-cycle core and drives the PC, IR, ALU, register-file and memory enables.

## Interface
- No parameters; opcode encodings fixed: R 0110011, I 0010011, lw 0000011, sw 0100011, beq 1100011.
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- Op_i  in  7  opcode field from the instruction register, valid from the ID cycle on
- Zero_i  in  1  ALU zero flag, sampled in EX for beq
- mem_ready_i  in  1  memory acknowledge for the current InstRead/MemRead/MemWrite request
- PCWrite_o  out  1  PC load enable
- PCSrc_o  out  1  0 = PC+4, 1 = branch target
- IRWrite_o  out  1  instruction register load enable
- InstRead_o  out  1  instruction fetch request
- ALUOp_o  out  2  00 add, 01 subtract/compare, 10 funct-decoded
- ALUSrc_o  out  1  0 = rs2, 1 = immediate
- RegWrite_o  out  1  register-file write enable
- MemtoReg_o  out  1  write-back source: 1 = memory data register
- MemRead_o  out  1  data load request
- MemWrite_o  out  1  data store request
- done_o  out  1  one-cycle pulse in the last cycle of every instruction
- illegal_o  out  1  sticky illegal-opcode flag (MC_ILLEGAL_TRAP_EN only; tied 0 otherwise)

## Operation
- States: IF, ID, EX, MEM, WB (plus ERR when the trap is enabled); 3-bit encoding.
- IF: InstRead_o=1. While mem_ready_i=0, stay in IF. When mem_ready_i=1, assert IRWrite_o=1, PCWrite_o=1, PCSrc_o=0, and go to ID on that edge.
- ID: latch Op_i into op_q and go to EX. All enables are 0 in ID.
- EX, by op_q:
  - R: ALUOp=10, ALUSrc=0, then WB.
  - I: ALUOp=00, ALUSrc=1, then WB.
  - lw/sw: ALUOp=00, ALUSrc=1, then MEM.
  - beq: ALUOp=01, ALUSrc=0, PCSrc=1, PCWrite=Zero_i, done_o=1, then IF.
- MEM (lw): MemRead_o=1, held until mem_ready_i; then WB.
- MEM (sw): MemWrite_o=1, held until mem_ready_i; on that ack cycle done_o=1, then IF.
- WB: RegWrite_o=1, MemtoReg_o=1 for lw and 0 otherwise, done_o=1, then IF.
- Outputs are Moore-decoded from the state and op_q. In non-EX states ALUOp_o=00 and ALUSrc_o=0.
- mem_ready_i is ignored in ID, EX and WB. A request never drops before its ack.
- Unknown opcode (trap disabled): EX drives all enables 0, done_o=1, then IF; the instruction executes as a NOP.

## Timing
- Reset (async assert): state=IF, op_q=0, illegal_o=0.
- During reset every output is 0.
- After release, InstRead_o=1 from the first cycle.
- Minimum latency with zero-wait memory (mem_ready_i=1 in the request cycle):
  - beq: 3 cycles.
  - R, I, sw: 4 cycles.
  - lw: 5 cycles.
- Each memory wait cycle adds exactly one cycle.
- Reset asserted mid-instruction aborts it: no further PCWrite/RegWrite/MemWrite, and the FSM restarts in IF.
- At most one of InstRead_o, MemRead_o, MemWrite_o is high in any cycle.

## Configuration
- MC_ILLEGAL_TRAP_EN defined:
  - An unknown op_q in EX goes to ERR and sets illegal_o=1.
  - ERR holds all enables 0 and done_o=0.
  - ERR is left only by reset.
- Not defined:
  - No ERR state; illegal_o is tied 0.
  - Unknown opcodes complete as NOPs as described above.

## Test plan
- Reset, then add (Op 0110011), mem_ready_i=1 always → IF, ID, EX (ALUOp 10, ALUSrc 0), WB (RegWrite 1, MemtoReg 0); done_o in cycle 4.
- lw with mem_ready_i low 2 cycles in IF and 3 cycles in MEM → MemRead_o high 4 cycles, RegWrite+MemtoReg in WB; done_o in cycle 10.
- beq with Zero_i=1, then with Zero_i=0 → EX PCWrite=1/PCSrc=1, then PCWrite=0; done_o in cycle 3 each time.
- sw, zero-wait → MemWrite_o high exactly 1 cycle, RegWrite_o never high, done_o in cycle 4.
- rst_i pulsed during a lw MEM wait → all outputs 0 immediately; after release InstRead_o=1, no RegWrite for the aborted lw.
- Op 1111111 → with MC_ILLEGAL_TRAP_EN: illegal_o=1 from cycle 4, no further InstRead until reset; without it: NOP, done_o in cycle 3, next fetch follows.
